// File: rtl/branch_resolve_pkg.sv
// Shared pipeline definitions: branch opcodes, resolver FSM states, counter width.
package branch_resolve_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_BEQ  = 2'b01,
        OP_BNE  = 2'b10,
        OP_JR   = 2'b11
    } op_e;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_e;

endpackage

// File: rtl/branch_target.sv
// Combinational branch outcome and target for beq/bne/jr.
module branch_target
    import branch_resolve_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] pc4,
    input  logic [15:0] imm,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] imm_words;

    // Resolve taken/target; PC-relative targets wrap silently mod 2^32.
    always_comb begin
        imm_words = {{14{imm[15]}}, imm, 2'b00};
        taken     = 1'b0;
        target    = '0;
        case (op_e'(op))
            OP_BEQ: begin
                taken  = (rs_data == rt_data);
                target = pc4 + imm_words;
            end
            OP_BNE: begin
                taken  = (rs_data != rt_data);
                target = pc4 + imm_words;
            end
            OP_JR: begin
                taken  = 1'b1;
                target = rs_data;
            end
            default: begin
                taken  = 1'b0;
                target = '0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: load-use stall, redirect handshake, perf counters.
module branch_resolve
    import branch_resolve_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [1:0]       id_op,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic [31:0]      id_pc4,
    input  logic [15:0]      id_imm,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_wr_addr,
    input  logic             redirect_ready,
    output logic             id_stall,
    output logic             ex_bubble,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] stall_count
);

    state_e      state_q, state_d;
    logic        is_branch;
    logic        hazard;
    logic        decide;
    logic        taken;
    logic [31:0] target;

    branch_target u_target (
        .op      (id_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .pc4     (id_pc4),
        .imm     (id_imm),
        .taken   (taken),
        .target  (target)
    );

    // Load-use hazard: a load in EX writing a register this branch reads (jr ignores rt).
    always_comb begin
        is_branch = id_valid && (op_e'(id_op) != OP_NONE);
        hazard    = is_branch && ex_mem_read && ex_reg_write && (ex_wr_addr != 5'd0) &&
                    ((ex_wr_addr == rs_addr) ||
                     ((op_e'(id_op) != OP_JR) && (ex_wr_addr == rt_addr)));
        decide    = (state_q == RUN) && is_branch && !hazard;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next state: enter PEND on a taken decision, leave when fetch accepts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (decide && taken) state_d = PEND;
            PEND:    if (redirect_ready)  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs: stall on hazard in RUN, hold the wrong-path slot while PEND; reset suppresses the flush.
    always_comb begin
        id_stall       = 1'b0;
        ex_bubble      = 1'b0;
        flush_ifid     = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            RUN: begin
                id_stall  = hazard;
                ex_bubble = hazard;
            end
            PEND: begin
                id_stall       = 1'b1;
                ex_bubble      = 1'b1;
                redirect_valid = 1'b1;
                flush_ifid     = redirect_ready && !rst;
            end
            default: ;
        endcase
    end

    // Redirect target capture and performance counters (only advance in RUN).
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc <= '0;
            br_count    <= '0;
            taken_count <= '0;
            stall_count <= '0;
        end else if (state_q == RUN) begin
            if (hazard) stall_count <= stall_count + 1'b1;
            if (decide) begin
                br_count <= br_count + 1'b1;
                if (taken) begin
                    taken_count <= taken_count + 1'b1;
                    redirect_pc <= target;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized run vs. a behavioural model.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [1:0]  id_op;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, id_pc4;
    logic [15:0] id_imm;
    logic        ex_mem_read, ex_reg_write;
    logic [4:0]  ex_wr_addr;
    logic        redirect_ready;
    logic        id_stall, ex_bubble, redirect_valid, flush_ifid;
    logic [31:0] redirect_pc, br_count, taken_count, stall_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic        m_pend;
    logic [31:0] m_rpc, m_br, m_tk, m_st;

    branch_resolve dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_op          (id_op),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .id_pc4         (id_pc4),
        .id_imm         (id_imm),
        .ex_mem_read    (ex_mem_read),
        .ex_reg_write   (ex_reg_write),
        .ex_wr_addr     (ex_wr_addr),
        .redirect_ready (redirect_ready),
        .id_stall       (id_stall),
        .ex_bubble      (ex_bubble),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .br_count       (br_count),
        .taken_count    (taken_count),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic f_haz();
        return id_valid && id_op != 2'b00 && ex_mem_read && ex_reg_write && ex_wr_addr != 5'd0 &&
               (ex_wr_addr == rs_addr || (id_op != 2'b11 && ex_wr_addr == rt_addr));
    endfunction

    // Advance the model using the current inputs, then clock the DUT and settle past the edge.
    task automatic tick();
        logic               tkn;
        logic signed [31:0] off;
        if (rst) begin
            m_pend = 1'b0; m_rpc = 0; m_br = 0; m_tk = 0; m_st = 0;
        end else if (m_pend) begin
            if (redirect_ready) m_pend = 1'b0;
        end else if (f_haz()) begin
            m_st = m_st + 1;
        end else if (id_valid && id_op != 2'b00) begin
            m_br = m_br + 1;
            tkn  = (id_op == 2'b11) || (id_op == 2'b01 ? rs_data == rt_data : rs_data != rt_data);
            if (tkn) begin
                m_tk   = m_tk + 1;
                off    = $signed(id_imm);
                m_rpc  = (id_op == 2'b11) ? rs_data : id_pc4 + 32'(off * 4);
                m_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_op = 2'b00; rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0;
        id_pc4 = 0; id_imm = 0; ex_mem_read = 0; ex_reg_write = 0; ex_wr_addr = 0;
        redirect_ready = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; tick(); tick(); rst = 0;
        repeat (5) tick();
        if (id_stall !== 1'b0)       begin bad++; $display("FAIL reset_stall got=%b exp=0", id_stall); end total++;
        if (ex_bubble !== 1'b0)      begin bad++; $display("FAIL reset_bubble got=%b exp=0", ex_bubble); end total++;
        if (flush_ifid !== 1'b0)     begin bad++; $display("FAIL reset_flush got=%b exp=0", flush_ifid); end total++;
        if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end total++;
        if (redirect_pc !== 32'h0)   begin bad++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end total++;
        if (br_count !== 32'h0)      begin bad++; $display("FAIL reset_br got=%0d exp=0", br_count); end total++;
        if (taken_count !== 32'h0)   begin bad++; $display("FAIL reset_tk got=%0d exp=0", taken_count); end total++;
        if (stall_count !== 32'h0)   begin bad++; $display("FAIL reset_st got=%0d exp=0", stall_count); end total++;
    endtask

    task automatic test_beq_taken();
        do_reset();
        id_valid = 1; id_op = 2'b01; rs_data = 32'h5; rt_data = 32'h5;
        id_pc4 = 32'h100; id_imm = 16'hFFFE; redirect_ready = 1;
        #1;
        if (id_stall !== 1'b0) begin bad++; $display("FAIL beq_decide_stall got=%b exp=0", id_stall); end total++;
        tick();
        set_idle(); redirect_ready = 1; #1;
        if (redirect_valid !== 1'b1)  begin bad++; $display("FAIL beq_rv got=%b exp=1", redirect_valid); end total++;
        if (redirect_pc !== 32'hF8)   begin bad++; $display("FAIL beq_rpc got=%h exp=000000f8", redirect_pc); end total++;
        if (flush_ifid !== 1'b1)      begin bad++; $display("FAIL beq_flush got=%b exp=1", flush_ifid); end total++;
        if (id_stall !== 1'b1)        begin bad++; $display("FAIL beq_pend_stall got=%b exp=1", id_stall); end total++;
        if (br_count !== 32'd1)       begin bad++; $display("FAIL beq_br got=%0d exp=1", br_count); end total++;
        if (taken_count !== 32'd1)    begin bad++; $display("FAIL beq_tk got=%0d exp=1", taken_count); end total++;
        tick();
        if (redirect_valid !== 1'b0)  begin bad++; $display("FAIL beq_rv_clear got=%b exp=0", redirect_valid); end total++;
        if (flush_ifid !== 1'b0)      begin bad++; $display("FAIL beq_flush_clear got=%b exp=0", flush_ifid); end total++;
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1; ex_reg_write = 1; ex_wr_addr = 5'd8;
        id_valid = 1; id_op = 2'b10; rs_addr = 5'd8; rt_addr = 5'd9;
        rs_data = 32'h3; rt_data = 32'h3; id_pc4 = 32'h200; id_imm = 16'h0004;
        #1;
        if (id_stall !== 1'b1)  begin bad++; $display("FAIL lu_stall got=%b exp=1", id_stall); end total++;
        if (ex_bubble !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%b exp=1", ex_bubble); end total++;
        tick();
        // Load has moved to MEM; EX now holds the injected bubble and rs is forwarded.
        ex_mem_read = 0; ex_reg_write = 0; ex_wr_addr = 0; rs_data = 32'h7;
        #1;
        if (id_stall !== 1'b0)     begin bad++; $display("FAIL lu_stall_once got=%b exp=0", id_stall); end total++;
        if (ex_bubble !== 1'b0)    begin bad++; $display("FAIL lu_bubble_once got=%b exp=0", ex_bubble); end total++;
        if (stall_count !== 32'd1) begin bad++; $display("FAIL lu_st got=%0d exp=1", stall_count); end total++;
        if (br_count !== 32'd0)    begin bad++; $display("FAIL lu_br_during_stall got=%0d exp=0", br_count); end total++;
        tick();
        set_idle();
        if (br_count !== 32'd1)        begin bad++; $display("FAIL lu_br got=%0d exp=1", br_count); end total++;
        if (taken_count !== 32'd1)     begin bad++; $display("FAIL lu_tk got=%0d exp=1", taken_count); end total++;
        if (redirect_pc !== 32'h210)   begin bad++; $display("FAIL lu_rpc got=%h exp=00000210", redirect_pc); end total++;
        if (stall_count !== 32'd1)     begin bad++; $display("FAIL lu_st_final got=%0d exp=1", stall_count); end total++;
    endtask

    task automatic test_jr_hold();
        do_reset();
        id_valid = 1; id_op = 2'b11; rs_addr = 5'd31; rs_data = 32'h400; redirect_ready = 0;
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            redirect_ready = (i == 3);
            #1;
            if (redirect_valid !== 1'b1)    begin bad++; $display("FAIL jr_rv[%0d] got=%b exp=1", i, redirect_valid); end total++;
            if (redirect_pc !== 32'h400)    begin bad++; $display("FAIL jr_rpc[%0d] got=%h exp=00000400", i, redirect_pc); end total++;
            if (id_stall !== 1'b1)          begin bad++; $display("FAIL jr_stall[%0d] got=%b exp=1", i, id_stall); end total++;
            if (flush_ifid !== (i == 3))    begin bad++; $display("FAIL jr_flush[%0d] got=%b exp=%b", i, flush_ifid, i == 3); end total++;
            tick();
        end
        if (redirect_valid !== 1'b0) begin bad++; $display("FAIL jr_rv_clear got=%b exp=0", redirect_valid); end total++;
        if (taken_count !== 32'd1)   begin bad++; $display("FAIL jr_tk got=%0d exp=1", taken_count); end total++;
    endtask

    task automatic test_bne_not_taken();
        do_reset();
        id_valid = 1; id_op = 2'b10; rs_data = 32'h33; rt_data = 32'h33; id_pc4 = 32'h40; id_imm = 16'h10;
        tick();
        set_idle(); #1;
        if (redirect_valid !== 1'b0) begin bad++; $display("FAIL bne_nt_rv got=%b exp=0", redirect_valid); end total++;
        if (br_count !== 32'd1)      begin bad++; $display("FAIL bne_nt_br got=%0d exp=1", br_count); end total++;
        if (taken_count !== 32'd0)   begin bad++; $display("FAIL bne_nt_tk got=%0d exp=0", taken_count); end total++;
        if (id_stall !== 1'b0)       begin bad++; $display("FAIL bne_nt_stall got=%b exp=0", id_stall); end total++;
    endtask

    task automatic test_hazard_edges();
        do_reset();
        ex_mem_read = 1; ex_reg_write = 1; ex_wr_addr = 5'd0;
        id_valid = 1; id_op = 2'b01; rs_addr = 5'd0; rt_addr = 5'd3;
        #1;
        if (id_stall !== 1'b0) begin bad++; $display("FAIL haz_r0 got=%b exp=0", id_stall); end total++;
        id_op = 2'b11; rs_addr = 5'd4; rt_addr = 5'd9; ex_wr_addr = 5'd9;
        #1;
        if (id_stall !== 1'b0) begin bad++; $display("FAIL haz_jr_rt got=%b exp=0", id_stall); end total++;
        id_op = 2'b01;
        #1;
        if (id_stall !== 1'b1) begin bad++; $display("FAIL haz_beq_rt got=%b exp=1", id_stall); end total++;
        ex_mem_read = 0;
        #1;
        if (id_stall !== 1'b0) begin bad++; $display("FAIL haz_alu got=%b exp=0", id_stall); end total++;
        ex_mem_read = 1; id_valid = 0;
        #1;
        if (id_stall !== 1'b0) begin bad++; $display("FAIL haz_invalid got=%b exp=0", id_stall); end total++;
        set_idle();
    endtask

    task automatic test_wrap();
        do_reset();
        id_valid = 1; id_op = 2'b01; rs_data = 32'h9; rt_data = 32'h9;
        id_pc4 = 32'hFFFF_FFFC; id_imm = 16'h0001;
        tick();
        set_idle(); #1;
        if (redirect_valid !== 1'b1) begin bad++; $display("FAIL wrap_rv got=%b exp=1", redirect_valid); end total++;
        if (redirect_pc !== 32'h0)   begin bad++; $display("FAIL wrap_rpc got=%h exp=00000000", redirect_pc); end total++;
    endtask

    task automatic test_reset_in_pend();
        do_reset();
        id_valid = 1; id_op = 2'b11; rs_data = 32'h80;
        tick();
        set_idle(); rst = 1; redirect_ready = 1; #1;
        if (flush_ifid !== 1'b0) begin bad++; $display("FAIL rstpend_flush got=%b exp=0", flush_ifid); end total++;
        tick();
        rst = 0; redirect_ready = 0; #1;
        if (redirect_valid !== 1'b0) begin bad++; $display("FAIL rstpend_rv got=%b exp=0", redirect_valid); end total++;
        if (redirect_pc !== 32'h0)   begin bad++; $display("FAIL rstpend_rpc got=%h exp=0", redirect_pc); end total++;
        if (id_stall !== 1'b0)       begin bad++; $display("FAIL rstpend_stall got=%b exp=0", id_stall); end total++;
    endtask

    task automatic test_random();
        logic e_stall, e_flush;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 79) == 0);
            id_valid       = ($urandom_range(0, 3) != 0);
            id_op          = 2'($urandom_range(0, 3));
            rs_addr        = 5'($urandom_range(0, 3));
            rt_addr        = 5'($urandom_range(0, 3));
            rs_data        = 32'($urandom_range(0, 2));
            rt_data        = 32'($urandom_range(0, 2));
            if (id_op == 2'b11 && $urandom_range(0, 1) == 1) rs_data = $urandom;
            id_pc4         = $urandom;
            id_imm         = 16'($urandom);
            ex_mem_read    = ($urandom_range(0, 1) == 1);
            ex_reg_write   = ($urandom_range(0, 3) != 0);
            ex_wr_addr     = 5'($urandom_range(0, 3));
            redirect_ready = ($urandom_range(0, 2) != 0);
            #1;
            e_stall = m_pend || f_haz();
            e_flush = m_pend && redirect_ready && !rst;
            if (id_stall !== e_stall)       begin bad++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", n, id_stall, e_stall); end total++;
            if (ex_bubble !== e_stall)      begin bad++; $display("FAIL rnd_bubble[%0d] got=%b exp=%b", n, ex_bubble, e_stall); end total++;
            if (flush_ifid !== e_flush)     begin bad++; $display("FAIL rnd_flush[%0d] got=%b exp=%b", n, flush_ifid, e_flush); end total++;
            if (redirect_valid !== m_pend)  begin bad++; $display("FAIL rnd_rv[%0d] got=%b exp=%b", n, redirect_valid, m_pend); end total++;
            if (redirect_pc !== m_rpc)      begin bad++; $display("FAIL rnd_rpc[%0d] got=%h exp=%h", n, redirect_pc, m_rpc); end total++;
            if (br_count !== m_br)          begin bad++; $display("FAIL rnd_br[%0d] got=%0d exp=%0d", n, br_count, m_br); end total++;
            if (taken_count !== m_tk)       begin bad++; $display("FAIL rnd_tk[%0d] got=%0d exp=%0d", n, taken_count, m_tk); end total++;
            if (stall_count !== m_st)       begin bad++; $display("FAIL rnd_st[%0d] got=%0d exp=%0d", n, stall_count, m_st); end total++;
            tick();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        set_idle();
        m_pend = 0; m_rpc = 0; m_br = 0; m_tk = 0; m_st = 0;
        test_reset();
        test_beq_taken();
        test_load_use();
        test_jr_hold();
        test_bne_not_taken();
        test_hazard_edges();
        test_wrap();
        test_reset_in_pend();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
